pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates write-enables, flushes and bubble injects, so that load-use hazards, taken branches and multi-cycle EX operations are resolved without software NOPs.
- Also produces the EX-stage operand forwarding selects from the EX/MEM and MEM/WB destination and regwrite fields.
- Sits beside the pipeline registers; has no datapath of its own.

Parameters:
- MC_LAT, 4, total EX-stage occupancy in cycles of a multi-cycle op (mul/div); legal range 1..32.
- CNT_W, 32, width of the optional stall counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- id_rs_i  in  5  rs field of the instruction in IF/ID.
- id_rt_i  in  5  rt field of the instruction in IF/ID.
- id_uses_rt_i  in  1  the ID instruction reads rt as a source.
- id_branch_taken_i  in  1  branch/jump in ID resolved taken.
- ex_memread_i  in  1  the ID/EX instruction is a load.
- ex_mc_i  in  1  the ID/EX instruction is a multi-cycle op.
- ex_rs_i  in  5  rs address held in ID/EX.
- ex_rt_i  in  5  rt address held in ID/EX.
- mem_regwrite_i  in  1  regwrite held in EX/MEM.
- mem_rd_i  in  5  destination held in EX/MEM.
- wb_regwrite_i  in  1  regwrite held in MEM/WB.
- wb_rd_i  in  5  destination held in MEM/WB.
- pc_we_o  out  1  PC load enable.
- ifid_we_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP (all zeros).
- idex_we_o  out  1  ID/EX load enable.
- idex_bubble_o  out  1  ID/EX loads zeroed control (regwrite=0, memread=0, mc=0).
- exmem_bubble_o  out  1  EX/MEM loads regwrite=0.
- fwd_a_o  out  2  ALU operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- fwd_b_o  out  2  ALU operand B select, same encoding.
- mc_busy_o  out  1  multi-cycle op occupying EX.

Behaviour:
- State register: RUN or MC_WAIT, plus down-counter mc_cnt of width $clog2(MC_LAT+1).
- While rst_n_i is low, regardless of inputs:
  - pc_we_o=0, ifid_we_o=0, idex_we_o=0, ifid_flush_o=0.
  - idex_bubble_o=1, exmem_bubble_o=1.
  - fwd_a_o=00, fwd_b_o=00, mc_busy_o=0.
  - State=RUN, mc_cnt=0.
- A reset asserted mid-MC_WAIT aborts the operation immediately.
- Outputs are combinational from state, mc_cnt and current inputs; the decision takes effect at the next rising edge.
- Load-use hazard (lu) = ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
- RUN, priority order:
  1. ex_mc_i && MC_LAT>1: go to MC_WAIT with mc_cnt=MC_LAT-2. pc_we=ifid_we=idex_we=0, exmem_bubble=1, mc_busy=1. Any lu or branch is ignored this cycle.
  2. lu: pc_we=ifid_we=0, idex_bubble=1 (idex_we=1). Exactly one bubble per load; the branch is re-evaluated next cycle.
  3. id_branch_taken_i: all we=1, ifid_flush=1 for one cycle.
  4. Otherwise: all we=1, no flush, no bubble.
- MC_WAIT:
  - mc_busy=1.
  - While mc_cnt!=0: hold pc/IF/ID/ID/EX, exmem_bubble=1, decrement mc_cnt.
  - When mc_cnt==0 (final cycle): exmem_bubble=0, all we=1, return to RUN. lu and branch are evaluated as in RUN, rules 2–4.
  - A multi-cycle op therefore occupies EX for exactly MC_LAT cycles and writes EX/MEM once.
  - Back-to-back multi-cycle ops re-enter MC_WAIT the cycle after release.
- MC_LAT==1: ex_mc_i is ignored; MC_WAIT is never entered.
- Forwarding, evaluated every cycle and independent of stalls:
  - fwd_a_o=10 if mem_regwrite_i && mem_rd_i!=0 && mem_rd_i==ex_rs_i.
  - Else fwd_a_o=01 if wb_regwrite_i && wb_rd_i!=0 && wb_rd_i==ex_rs_i.
  - Else fwd_a_o=00.
  - fwd_b_o follows the same rules using ex_rt_i.
  - EX/MEM match has priority over MEM/WB.
- Register $0 never triggers a hazard or forwarding.

Optional Feature:
- Macro: PIPE_HAZARD_STALL_CNT_EN.
- When defined, add output stall_cnt_o [CNT_W-1:0]:
  - Reset value 0.
  - Increments on each cycle in which pc_we_o=0 while rst_n_i=1.
  - Saturates at all-ones; no wrap.
  - Adds input stall_cnt_clr_i (1 bit), which zeroes the counter synchronously and takes priority over increment.
- When undefined, neither port exists and there is no counter logic.

Test Plan:
- Reset mid-MC_WAIT (MC_LAT=4, cycle 2): rst_n_i low → outputs immediately take reset values. After release with ex_mc_i=0 → pc_we_o=1 on the first cycle.
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 → one cycle with pc_we=0, ifid_we=0, idex_bubble=1. Next cycle (ex_memread=0) → pc_we=1. Repeat with ex_rt=0 → no stall.
- Branch taken, with lu and without:
  - id_branch_taken=1, no lu → ifid_flush=1 for one cycle, pc_we=1.
  - Same with lu → stall first, then flush on the following cycle.
- Multi-cycle, MC_LAT=4, ex_mc held 1:
  - mc_busy high for 4 cycles, exmem_bubble high for the first 3, pc_we low for the first 3.
  - A second multi-cycle op immediately after → another 4 cycles.
- Forwarding:
  - mem_rd=ex_rs=7 and wb_rd=7, both regwrite=1 → fwd_a=10.
  - mem_regwrite=0 → fwd_a=01.
  - ex_rt=0 with wb_rd=0 → fwd_b=00.
- With PIPE_HAZARD_STALL_CNT_EN: the 3 load-use stalls plus one MC_LAT=4 op → stall_cnt_o=6. Pulse stall_cnt_clr_i → 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the hazard-controller side of the pipeline.
//   master : the pipeline registers, which supply the stage fields and
//            consume the enables and selects.
//   slave  : the hazard controller itself.
//   The optional stall counter is not part of this bundle. When the
//   PIPE_HAZARD_STALL_CNT_EN macro is defined, the counter appears as two
//   plain ports on pipe_hazard_ctrl.
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

    // Decode-stage fields (IF/ID)
    logic [4:0] id_rs_i;
    logic [4:0] id_rt_i;
    logic       id_uses_rt_i;
    logic       id_branch_taken_i;

    // Execute-stage fields (ID/EX)
    logic       ex_memread_i;
    logic       ex_mc_i;
    logic [4:0] ex_rs_i;
    logic [4:0] ex_rt_i;

    // Writer fields of the two downstream stages
    logic       mem_regwrite_i;
    logic [4:0] mem_rd_i;
    logic       wb_regwrite_i;
    logic [4:0] wb_rd_i;

    // Pipeline-register controls
    logic       pc_we_o;
    logic       ifid_we_o;
    logic       ifid_flush_o;
    logic       idex_we_o;
    logic       idex_bubble_o;
    logic       exmem_bubble_o;

    // Forwarding selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;
    logic       mc_busy_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, id_branch_taken_i,
        output ex_memread_i, ex_mc_i, ex_rs_i, ex_rt_i,
        output mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
        input  idex_bubble_o, exmem_bubble_o, fwd_a_o, fwd_b_o, mc_busy_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, id_branch_taken_i,
        input  ex_memread_i, ex_mc_i, ex_rs_i, ex_rt_i,
        input  mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
        output idex_bubble_o, exmem_bubble_o, fwd_a_o, fwd_b_o, mc_busy_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Sequencing controller for a 5-stage pipeline. It produces the
//   write-enables, flushes and bubbles for the IF/ID, ID/EX and EX/MEM
//   registers. It resolves load-use hazards, taken branches and multi-cycle
//   EX operations, and it generates the EX-stage forwarding selects.
//   The controller has no datapath of its own.
//
//   Optional feature (macro PIPE_HAZARD_STALL_CNT_EN):
//     Adds a saturating stall counter, stall_cnt_o, with a synchronous
//     clear input, stall_cnt_clr_i.
//
//   Parameters:
//     MC_LAT : total number of EX cycles a multi-cycle op occupies (1..32).
//              With MC_LAT == 1, ex_mc_i is ignored.
//     CNT_W  : width of the optional stall counter.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
`ifdef PIPE_HAZARD_STALL_CNT_EN
    input  logic             stall_cnt_clr_i,
    output logic [CNT_W-1:0] stall_cnt_o,
`endif
    pipe_hazard_ctrl_if.slave bus
);

    // Reject nonsensical configurations at elaboration time
    if (MC_LAT < 1 || MC_LAT > 32 || CNT_W < 1) begin : g_bad_params
        $error("pipe_hazard_ctrl: MC_LAT must be 1..32 and CNT_W must be >= 1");
    end

    // The counter holds "EX cycles still to wait".
    // It is loaded with MC_LAT-2 because:
    //   - the cycle that enters MC_WAIT is one EX cycle, and
    //   - the release cycle is another EX cycle.
    localparam int CW      = $clog2(MC_LAT + 1);
    localparam bit MC_EN   = (MC_LAT > 1);
    localparam int MC_LOAD = MC_EN ? (MC_LAT - 2) : 0;
    localparam logic [CW-1:0] MC_LOAD_V = CW'(MC_LOAD);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   mc_cnt_q, mc_cnt_d;

    logic            lu;
    logic            apply_rules;
    logic            pc_we, ifid_we, ifid_flush, idex_we;
    logic            idex_bubble, exmem_bubble, mc_busy;
    logic [1:0]      fwd_a, fwd_b;

    // Load-use hazard. The load's destination ($0 excluded) is read by the
    // decode-stage instruction.
    always_comb begin
        lu = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
             ((bus.ex_rt_i == bus.id_rs_i) ||
              (bus.id_uses_rt_i && (bus.ex_rt_i == bus.id_rt_i)));
    end

    // Next-state and pipeline-control decode. Priority: multi-cycle entry,
    // then load-use, then taken branch.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mc_busy      = 1'b0;
        apply_rules  = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.ex_mc_i && MC_EN) begin
                    // Freeze the front end while the op owns EX. Any hazard
                    // or branch is re-examined at the release cycle.
                    state_d      = MC_WAIT;
                    mc_cnt_d     = MC_LOAD_V;
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    mc_busy      = 1'b1;
                end else begin
                    apply_rules = 1'b1;
                end
            end

            MC_WAIT: begin
                mc_busy = 1'b1;
                if (mc_cnt_q != '0) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    mc_cnt_d     = mc_cnt_q - CW'(1);
                end else begin
                    // Final EX cycle. The result enters EX/MEM once, and
                    // the front end resumes subject to the normal rules.
                    state_d     = RUN;
                    apply_rules = 1'b1;
                end
            end

            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase

        if (apply_rules) begin
            if (lu) begin
                // A single bubble behind the load. A branch in ID waits and
                // is seen again next cycle.
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (bus.id_branch_taken_i) begin
                ifid_flush = 1'b1;
            end
        end

        // Reset overrides everything, even though the input is asynchronous
        if (!rst_n_i) begin
            state_d      = RUN;
            mc_cnt_d     = '0;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            mc_busy      = 1'b0;
        end
    end

    // EX operand forwarding. The EX/MEM stage holds the newer value and wins
    // over MEM/WB. $0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (bus.mem_regwrite_i && (bus.mem_rd_i != 5'd0) && (bus.mem_rd_i == bus.ex_rs_i))
            fwd_a = 2'b10;
        else if (bus.wb_regwrite_i && (bus.wb_rd_i != 5'd0) && (bus.wb_rd_i == bus.ex_rs_i))
            fwd_a = 2'b01;

        if (bus.mem_regwrite_i && (bus.mem_rd_i != 5'd0) && (bus.mem_rd_i == bus.ex_rt_i))
            fwd_b = 2'b10;
        else if (bus.wb_regwrite_i && (bus.wb_rd_i != 5'd0) && (bus.wb_rd_i == bus.ex_rt_i))
            fwd_b = 2'b01;

        if (!rst_n_i) begin
            fwd_a = 2'b00;
            fwd_b = 2'b00;
        end
    end

    // State and multi-cycle counter registers. An asynchronous reset aborts
    // any op in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // flop samples the values from before the edge.
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign bus.pc_we_o        = pc_we;
    assign bus.ifid_we_o      = ifid_we;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_we_o      = idex_we;
    assign bus.idex_bubble_o  = idex_bubble;
    assign bus.exmem_bubble_o = exmem_bubble;
    assign bus.fwd_a_o        = fwd_a;
    assign bus.fwd_b_o        = fwd_b;
    assign bus.mc_busy_o      = mc_busy;

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter. Clear wins over increment, and the count saturates at
    // all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr_i)
            stall_cnt_d = '0;
        else if (!pc_we && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Stall counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Scoreboard bench for pipe_hazard_ctrl (MC_LAT = 4).
//   Timing of each cycle:
//     - Stimulus is driven 1 time unit after the rising edge.
//     - The reference model turns that stimulus into the expected outputs
//       and pushes them onto a queue.
//     - A monitor pops the queue on the falling edge and compares.
//   The reference model tracks the position of a multi-cycle op inside its
//   MC_LAT-cycle EX occupancy, plus a plain integer stall count.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MC_LAT = 4;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic             stall_cnt_clr;
    logic [CNT_W-1:0] stall_cnt;
`endif

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
`ifdef PIPE_HAZARD_STALL_CNT_EN
        .stall_cnt_clr_i (stall_cnt_clr),
        .stall_cnt_o     (stall_cnt),
`endif
        .bus             (bus)
    );

    typedef struct packed {
        logic       rst_n;
        logic       clr;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       br;
        logic       memread;
        logic       mc;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic       mem_rw;
        logic [4:0] mem_rd;
        logic       wb_rw;
        logic [4:0] wb_rd;
    } stim_t;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       ifid_flush;
        logic       idex_we;
        logic       idex_bubble;
        logic       exmem_bubble;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       mc_busy;
    } resp_t;

    typedef struct packed {
        resp_t            r;
        logic [CNT_W-1:0] cnt;
        logic [31:0]      cyc;
    } exp_t;

    exp_t             exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    int               mc_k   = 0;    // EX cycle index of the current multi-cycle op; 0 = none
    logic [CNT_W-1:0] stall_model = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%b expected=%b", name, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd_sel(input logic mrw, input logic [4:0] mrd,
                                          input logic wrw, input logic [4:0] wrd,
                                          input logic [4:0] src);
        if (src == 0)                return 2'b00;
        if (mrw && mrd == src)       return 2'b10;
        if (wrw && wrd == src)       return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: expected outputs for this cycle, then advance the
    // model to the next edge
    task automatic model(input stim_t s, output resp_t r, output logic [CNT_W-1:0] cnt);
        int  k;
        bit  lu;
        r = '0;
        if (!s.rst_n) begin
            r.idex_bubble  = 1'b1;
            r.exmem_bubble = 1'b1;
            mc_k        = 0;
            stall_model = '0;
            cnt         = '0;
            return;
        end
        cnt     = stall_model;
        r.fwd_a = fwd_sel(s.mem_rw, s.mem_rd, s.wb_rw, s.wb_rd, s.ex_rs);
        r.fwd_b = fwd_sel(s.mem_rw, s.mem_rd, s.wb_rw, s.wb_rd, s.ex_rt);
        k = mc_k;
        if (k == 0 && s.mc && MC_LAT > 1) k = 1;
        if (k > 0 && k < MC_LAT) begin
            // Op still occupies EX: front end frozen, nothing leaves EX
            r.mc_busy      = 1'b1;
            r.exmem_bubble = 1'b1;
            mc_k = k + 1;
        end else begin
            r.mc_busy = (k == MC_LAT);
            mc_k = 0;
            lu = s.memread && s.ex_rt != 0 &&
                 (s.ex_rt == s.id_rs || (s.uses_rt && s.ex_rt == s.id_rt));
            r.pc_we       = !lu;
            r.ifid_we     = !lu;
            r.idex_we     = 1'b1;
            r.idex_bubble = lu;
            r.ifid_flush  = !lu && s.br;
        end
        if (s.clr)
            stall_model = '0;
        else if (!r.pc_we && stall_model != '1)
            stall_model = stall_model + 1;
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                 = s.rst_n;
        bus.id_rs_i           = s.id_rs;
        bus.id_rt_i           = s.id_rt;
        bus.id_uses_rt_i      = s.uses_rt;
        bus.id_branch_taken_i = s.br;
        bus.ex_memread_i      = s.memread;
        bus.ex_mc_i           = s.mc;
        bus.ex_rs_i           = s.ex_rs;
        bus.ex_rt_i           = s.ex_rt;
        bus.mem_regwrite_i    = s.mem_rw;
        bus.mem_rd_i          = s.mem_rd;
        bus.wb_regwrite_i     = s.wb_rw;
        bus.wb_rd_i           = s.wb_rd;
`ifdef PIPE_HAZARD_STALL_CNT_EN
        stall_cnt_clr         = s.clr;
`endif
        model(s, e.r, e.cnt);
        e.cyc = cyc;
        cyc++;
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Monitor: compare DUT outputs against the scoreboard every falling edge
    initial begin
        exp_t  e;
        resp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{bus.pc_we_o, bus.ifid_we_o, bus.ifid_flush_o, bus.idex_we_o,
                        bus.idex_bubble_o, bus.exmem_bubble_o, bus.fwd_a_o,
                        bus.fwd_b_o, bus.mc_busy_o};
                check($sformatf("resp cyc %0d", e.cyc), 64'(got), 64'(e.r));
`ifdef PIPE_HAZARD_STALL_CNT_EN
                check($sformatf("stall_cnt cyc %0d", e.cyc), 64'(stall_cnt), 64'(e.cnt));
`endif
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic
    initial begin
        stim_t s;
        bus.id_rs_i = '0; bus.id_rt_i = '0; bus.id_uses_rt_i = 1'b0;
        bus.id_branch_taken_i = 1'b0; bus.ex_memread_i = 1'b0; bus.ex_mc_i = 1'b0;
        bus.ex_rs_i = '0; bus.ex_rt_i = '0; bus.mem_regwrite_i = 1'b0;
        bus.mem_rd_i = '0; bus.wb_regwrite_i = 1'b0; bus.wb_rd_i = '0;
`ifdef PIPE_HAZARD_STALL_CNT_EN
        stall_cnt_clr = 1'b0;
`endif
        // Reset
        s = idle(); s.rst_n = 1'b0;
        apply(s); apply(s);
        apply(idle());

        // Load-use via rs, then resolved, then $0 (no stall), then via rt
        s = idle(); s.memread = 1; s.ex_rt = 5; s.id_rs = 5; apply(s);
        apply(idle());
        s = idle(); s.memread = 1; s.ex_rt = 0; s.id_rs = 0; apply(s);
        s = idle(); s.memread = 1; s.ex_rt = 9; s.id_rt = 9; s.uses_rt = 1; apply(s);
        s.uses_rt = 0; apply(s);

        // Branch alone, then branch behind a load-use
        s = idle(); s.br = 1; apply(s);
        s = idle(); s.br = 1; s.memread = 1; s.ex_rt = 3; s.id_rs = 3; apply(s);
        s = idle(); s.br = 1; apply(s);
        apply(idle());

        // Two back-to-back multi-cycle ops, with hazards present during the wait
        for (int i = 0; i < 2 * MC_LAT; i++) begin
            s = idle(); s.mc = 1; s.br = (i == 2); s.id_rs = 4; s.ex_rt = 4;
            apply(s);
        end
        apply(idle());

        // Forwarding priority and $0
        s = idle(); s.ex_rs = 7; s.mem_rd = 7; s.wb_rd = 7; s.mem_rw = 1; s.wb_rw = 1; apply(s);
        s.mem_rw = 0; apply(s);
        s = idle(); s.ex_rt = 0; s.wb_rd = 0; s.wb_rw = 1; s.mem_rw = 1; apply(s);
        s = idle(); s.ex_rt = 12; s.mem_rd = 12; s.wb_rd = 12; s.mem_rw = 1; s.wb_rw = 1; apply(s);

        // Clear the stall count, then reset in the middle of a multi-cycle op
        s = idle(); s.clr = 1; apply(s);
        s = idle(); s.mc = 1; apply(s); apply(s);
        s.rst_n = 0; apply(s);
        apply(idle());

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst_n   = ($urandom_range(0, 60) != 0);
            s.clr     = ($urandom_range(0, 19) == 0);
            s.id_rs   = 5'($urandom_range(0, 7));
            s.id_rt   = 5'($urandom_range(0, 7));
            s.uses_rt = 1'($urandom);
            s.br      = ($urandom_range(0, 3) == 0);
            s.memread = ($urandom_range(0, 2) == 0);
            s.mc      = ($urandom_range(0, 5) == 0);
            s.ex_rs   = 5'($urandom_range(0, 7));
            s.ex_rt   = 5'($urandom_range(0, 7));
            s.mem_rw  = 1'($urandom);
            s.mem_rd  = 5'($urandom_range(0, 7));
            s.wb_rw   = 1'($urandom);
            s.wb_rd   = 5'($urandom_range(0, 7));
            apply(s);
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
